// File: rtl/ram64_dma.sv
// Block-transfer sequencer in front of RAM64: streams a valid/ready source into a
// contiguous RAM range (write) or a RAM range out to a sink (read). Optional macro: DMA_CHECKSUM_EN.
//
// state | meaning
// IDLE  | waiting for start; base/len/dir sampled here
// WRITE | accepting source words, one RAM write per s_valid cycle
// READ  | presenting RAM words to the sink, advancing on m_ready
// DONE  | one-cycle done pulse, then back to IDLE
module ram64_dma #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              dir,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
`ifdef DMA_CHECKSUM_EN
    output logic [DATA_W-1:0] csum,
`endif
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    output logic              ram_load,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_in,
    input  logic [DATA_W-1:0] ram_out
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(1 << ADDR_W);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [ADDR_W:0]   remaining_q, remaining_d;
    logic              hs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        hs          = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cur_addr_d  = base;
                    remaining_d = (len > DEPTH) ? DEPTH : len;
                    if (len == '0)
                        state_d = DONE;
                    else
                        state_d = dir ? READ : WRITE;
                end
            end
            WRITE:   hs = s_valid;
            READ:    hs = m_ready;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Address wraps naturally at the RAM depth.
        if (hs) begin
            cur_addr_d  = cur_addr_q + 1'b1;
            remaining_d = remaining_q - 1'b1;
            if (remaining_q == (ADDR_W+1)'(1))
                state_d = DONE;
        end
    end

    assign busy        = (state_q == WRITE) || (state_q == READ);
    assign done        = (state_q == DONE);
    assign s_ready     = (state_q == WRITE);
    assign m_valid     = (state_q == READ);
    assign m_data      = ram_out;
    assign ram_load    = (state_q == WRITE) && s_valid;
    assign ram_address = cur_addr_q;
    assign ram_in      = ram_load ? s_data : '0;

`ifdef DMA_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q, csum_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            csum_q <= '0;
        else
            csum_q <= csum_d;
    end

    always_comb begin
        csum_d = csum_q;
        if (state_q == IDLE && start)
            csum_d = '0;
        else if (hs)
            csum_d = csum_q + ((state_q == WRITE) ? s_data : ram_out);
    end

    assign csum = csum_q;
`endif

endmodule

// File: tb/tb_ram64_dma.sv
// Self-checking bench for ram64_dma: table of transfers plus hand-written abort and
// start-in-DONE sequences, checked against a word-level model of RAM contents.
module tb_ram64_dma;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, dir;
    logic [5:0]  base;
    logic [6:0]  len;
    logic        busy, done;
    logic        s_valid, s_ready, m_valid, m_ready;
    logic [15:0] s_data, m_data;
    logic        ram_load;
    logic [5:0]  ram_address;
    logic [15:0] ram_in, ram_out;
`ifdef DMA_CHECKSUM_EN
    logic [15:0] csum;
`endif

    always #5 clk = ~clk;

    ram64_dma #(.ADDR_W(6), .DATA_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dir(dir), .base(base), .len(len),
        .busy(busy), .done(done),
`ifdef DMA_CHECKSUM_EN
        .csum(csum),
`endif
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .ram_load(ram_load), .ram_address(ram_address), .ram_in(ram_in), .ram_out(ram_out)
    );

    // RAM64 itself: synchronous write, combinational read.
    logic [15:0] mem [64];
    always @(posedge clk) if (ram_load) mem[ram_address] <= ram_in;
    assign ram_out = mem[ram_address];

    logic [15:0] ref_mem [64];
    logic [15:0] src_data [64];
    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        bit d; int base; int len; int stall; int dsel; int exp_n; int exp_end;
    } vec_t;
    vec_t vt[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Called and returns at posedge+1. stall<0 means m_ready/s_valid toggles 1,0,1,0.
    task automatic xfer(input bit d, input int b, input int l, input int stall,
                        input int exp_n, input int exp_end, input string tag);
        int addr, got, cyc, stalls, iter;
        logic [15:0] sum;
        bit hs;
        addr = b; got = 0; cyc = 0; stalls = 0; iter = 0; sum = '0;
        start = 1'b1; dir = d; base = 6'(b); len = 7'(l); s_valid = 1'b0; m_ready = 1'b0;
        #1;
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
        start = 1'b0; cyc = 1;
        while (got < exp_n && cyc < 400) begin
            if (stall < 0) hs = (iter % 2 == 0);
            else hs = ($urandom_range(99) >= 32'(stall));
            if (!d) begin s_valid = hs; s_data = hs ? src_data[got] : 16'($urandom); end
            else m_ready = hs;
            #1;
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            chk({tag, "_addr"}, 32'(ram_address), 32'(addr));
            if (!d) begin
                chk({tag, "_sready"}, 32'(s_ready), 32'd1);
                chk({tag, "_load"}, 32'(ram_load), 32'(hs));
                if (hs) chk({tag, "_ram_in"}, 32'(ram_in), 32'(src_data[got]));
            end else begin
                chk({tag, "_mvalid"}, 32'(m_valid), 32'd1);
                chk({tag, "_rd_load"}, 32'(ram_load), 32'd0);
                chk({tag, "_mdata"}, 32'(m_data), 32'(ref_mem[addr]));
            end
            if (hs) begin
                if (!d) begin ref_mem[addr] = src_data[got]; sum = sum + src_data[got]; end
                else sum = sum + ref_mem[addr];
                addr = (addr + 1) % 64;
                got++;
            end else stalls++;
            iter++;
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_no_timeout"}, 32'(cyc < 400), 32'd1);
        s_valid = 1'b0; m_ready = 1'b0;
        #1;
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_done_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done_load"}, 32'(ram_load), 32'd0);
        chk({tag, "_cycles"}, 32'(cyc), 32'(exp_n + 1 + stalls));
        chk({tag, "_end_addr"}, 32'(ram_address), 32'(exp_end));
`ifdef DMA_CHECKSUM_EN
        chk({tag, "_csum"}, 32'(csum), 32'(sum));
`endif
        @(posedge clk); #1;
        chk({tag, "_done_clr"}, 32'(done), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        chk({tag, "_idle_ram_in"}, 32'(ram_in), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i] = 16'($urandom);
            ref_mem[i] = mem[i];
        end
        rst_n = 1'b0; start = 1'b0; dir = 1'b0; base = '0; len = '0;
        s_valid = 1'b1; s_data = 16'hFFFF; m_ready = 1'b0;
        #3;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sready", 32'(s_ready), 32'd0);
        chk("rst_mvalid", 32'(m_valid), 32'd0);
        chk("rst_load", 32'(ram_load), 32'd0);
        chk("rst_addr", 32'(ram_address), 32'd0);
        chk("rst_ram_in", 32'(ram_in), 32'd0);
        s_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // {dir, base, len, stall%, data_sel, expected words, expected end address}
        vt[0] = '{0, 0, 4, 0, 1, 4, 4};
        vt[1] = '{1, 0, 4, 0, 0, 4, 4};
        vt[2] = '{0, 62, 4, 0, 2, 4, 2};
        vt[3] = '{1, 62, 4, -1, 0, 4, 2};
        vt[4] = '{0, 9, 0, 0, 0, 0, 9};
        vt[5] = '{0, 5, 100, 0, 0, 64, 5};
        vt[6] = '{1, 5, 100, 30, 0, 64, 5};
        vt[7] = '{0, 40, 3, 0, 3, 3, 43};
        vt[8] = '{1, 40, 3, 50, 0, 3, 43};
        vt[9] = '{1, 33, 0, 0, 0, 0, 33};
        for (int i = 10; i < 16; i++) begin
            int ln, bs;
            ln = int'($urandom_range(0, 127));
            bs = int'($urandom_range(0, 63));
            vt[i] = '{bit'($urandom_range(1)), bs, ln, 25, 0,
                      (ln > 64) ? 64 : ln, (bs + ((ln > 64) ? 64 : ln)) % 64};
        end

        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < 64; k++) src_data[k] = 16'($urandom);
            case (vt[i].dsel)
                1: begin src_data[0] = 16'hA000; src_data[1] = 16'hB111;
                         src_data[2] = 16'hC222; src_data[3] = 16'hDFFF; end
                2: for (int k = 0; k < 4; k++) src_data[k] = 16'(k + 1);
                3: begin src_data[0] = 16'h8000; src_data[1] = 16'h8001;
                         src_data[2] = 16'h0005; end
                default: ;
            endcase
            xfer(vt[i].d, vt[i].base, vt[i].len, vt[i].stall, vt[i].exp_n, vt[i].exp_end,
                 $sformatf("v%0d", i));
        end

        // start during DONE must be ignored
        start = 1'b1; dir = 1'b0; base = 6'd7; len = 7'd0;
        @(posedge clk); #1;
        len = 7'd4;
        #1;
        chk("dn_done", 32'(done), 32'd1);
        chk("dn_load", 32'(ram_load), 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        #1;
        chk("dn_ign_busy", 32'(busy), 32'd0);
        chk("dn_ign_sready", 32'(s_ready), 32'd0);
        chk("dn_ign_done", 32'(done), 32'd0);
        @(posedge clk); #1;

        // Abort: reset after 2 of 8 words; a start while busy is ignored
        start = 1'b1; dir = 1'b0; base = 6'd20; len = 7'd8;
        @(posedge clk); #1;
        start = 1'b0; s_valid = 1'b1; s_data = 16'h1111;
        #1;
        chk("ab_addr0", 32'(ram_address), 32'd20);
        chk("ab_load0", 32'(ram_load), 32'd1);
        ref_mem[20] = 16'h1111;
        @(posedge clk); #1;
        s_data = 16'h2222; start = 1'b1; dir = 1'b1; base = 6'd50; len = 7'd3;
        #1;
        chk("ab_addr1", 32'(ram_address), 32'd21);
        ref_mem[21] = 16'h2222;
        @(posedge clk); #1;
        start = 1'b0; s_data = 16'h3333;
        #1;
        chk("ab_start_ign_addr", 32'(ram_address), 32'd22);
        chk("ab_start_ign_sready", 32'(s_ready), 32'd1);
        chk("ab_start_ign_mvalid", 32'(m_valid), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("ab_load", 32'(ram_load), 32'd0);
        chk("ab_busy", 32'(busy), 32'd0);
        chk("ab_done", 32'(done), 32'd0);
        chk("ab_addr_rst", 32'(ram_address), 32'd0);
        @(posedge clk); #1;
        s_valid = 1'b0; rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("ab_no_done", 32'(done), 32'd0);
        end
        xfer(1'b1, 20, 8, 0, 8, 28, "ab_rd");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ram64_dma.md
Name: ram64_dma

Overview:
Block-transfer sequencer sitting directly upstream of RAM64; it owns the RAM64 load/address/in port and consumes RAM64 out.
- Write mode: streams words from a valid/ready source into a contiguous RAM64 range.
- Read mode: streams a contiguous RAM64 range out to a valid/ready sink.
- Throughput is one word per clock. A single start pulse launches each transfer.

Parameters:
ADDR_W, 6, RAM64 address width (64 words)
DATA_W, 16, word width, matches RAM64 in/out

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  reset, asynchronous, active-low
start  in  1  launch transfer; sampled only in IDLE
dir  in  1  0 = stream-to-RAM (write), 1 = RAM-to-stream (read); sampled with start
base  in  ADDR_W  first RAM address; sampled with start
len  in  ADDR_W+1  word count; sampled with start
busy  out  1  high in WRITE or READ
done  out  1  one-cycle pulse at transfer end
s_valid  in  1  write-source data valid
s_data  in  DATA_W  write-source data
s_ready  out  1  high in WRITE
m_valid  out  1  high in READ
m_data  out  DATA_W  read-sink data, equals ram_out
m_ready  in  1  read-sink ready
ram_load  out  1  to RAM64 load
ram_address  out  ADDR_W  to RAM64 address
ram_in  out  DATA_W  to RAM64 in
ram_out  in  DATA_W  from RAM64 out (combinational read of ram_address)

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE; cur_addr=0, remaining=0.
  - Outputs: busy=0, done=0, s_ready=0, m_valid=0, ram_load=0, ram_address=0, ram_in=0.
  - Reset mid-transfer aborts immediately, with no done pulse. ram_load drops in the same instant because it decodes combinationally from state.
- States: IDLE, WRITE, READ, DONE.
- IDLE:
  - On start=1 latch cur_addr=base and remaining=min(len,64); values above 64 clamp to 64.
  - len=0: go to DONE, no RAM access.
  - Otherwise go to WRITE if dir=0, or READ if dir=1.
- WRITE:
  - s_ready=1.
  - When s_valid=1: ram_load=1, ram_address=cur_addr, ram_in=s_data, all combinational. RAM64 commits the word at that rising edge.
  - On that edge: cur_addr+1 (mod 64), remaining-1. When remaining reaches 0, go to DONE.
  - When s_valid=0: ram_load=0, nothing advances.
- READ:
  - m_valid=1, ram_address=cur_addr, m_data=ram_out; ram_load=0 always.
  - On an edge with m_ready=1: cur_addr+1 (mod 64), remaining-1. When remaining reaches 0, go to DONE.
  - When m_ready=0: address and m_data hold stable.
- DONE: done=1 for exactly one cycle, then IDLE.
- start outside IDLE is ignored, including start in the DONE cycle.
- Address wrap: 63 is followed by 0. A transfer of 64 words from any base touches every word exactly once.
- Latency:
  - First handshake is possible in the cycle after the start edge.
  - done asserts in the cycle after the last handshake.
  - N-word transfer with no stalls: start edge to done = N+1 cycles.
- When not in WRITE: ram_address=cur_addr and ram_in=0.

Optional Feature:
Macro DMA_CHECKSUM_EN.
- Defined:
  - Extra output port csum (DATA_W) holds a 16-bit modulo-2^16 sum of every word handshaked in the current transfer.
  - csum clears to 0 on reset and on the start edge, and is valid while done=1.
  - Port order: csum follows done.
- Undefined: the port and its logic are absent; everything else is identical.

Test Plan:
- Write mode: reset, then start dir=0 base=0 len=4, and stream A000,B111,C222,DFFF with s_valid held high. Required: ram_load high 4 consecutive cycles at addresses 0..3, done at cycle 5 after start, busy low afterward.
- Read back: start dir=1 base=0 len=4 with m_ready=1. Required: m_data sequence A000,B111,C222,DFFF, then done pulse.
- Wrap plus backpressure: write base=62 len=4 with values 1,2,3,4. Then read it back with m_ready toggling 1,0,1,0. Required: addresses 62,63,0,1, m_data holds during m_ready=0, output 1,2,3,4.
- Edge lengths: len=0 gives a done pulse the cycle after start with no ram_load. len=100 clamps to exactly 64 writes.
- Abort: assert rst_n=0 in the middle of a write, after 2 of 8 words. Required: ram_load=0 immediately, no done, a later read shows only 2 words updated, and a start during busy is ignored.
- DMA_CHECKSUM_EN: write 0x8000,0x8001,0x0005. Required: csum=0x0006 while done=1.
